// File: rtl/pixel_upscaler_linebuf.sv
// Nearest-neighbour 2x upscaler: each source pixel becomes a 2x2 block.
// Even rows come from the source, odd rows are replayed from a line buffer.
module pixel_upscaler_linebuf #(
  parameter int GS_PXL_W = 8,
  parameter int COL_NUM  = 640,
  parameter int ROW_NUM  = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [GS_PXL_W-1:0] src_pxl_i,
  input  logic                src_pxl_vld_i,
  output logic                src_pxl_rdy_o,
  output logic [GS_PXL_W-1:0] dst_pxl_o,
  output logic                dst_pxl_vld_o,
  input  logic                dst_rdy_i,
  output logic                dst_eol_o,
  output logic                dst_eof_o
);

  localparam int HCOL = COL_NUM / 2;
  localparam int ICW  = (HCOL > 1) ? $clog2(HCOL) : 1;
  localparam int OCW  = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int ORW  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

  localparam logic [ICW-1:0] IC_LAST = ICW'(HCOL - 1);
  localparam logic [OCW-1:0] OC_LAST = OCW'(COL_NUM - 1);
  localparam logic [ORW-1:0] OR_LAST = ORW'(ROW_NUM - 1);

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ICW-1:0]      in_col_q, in_col_d;
  logic [OCW-1:0]      out_col_q, out_col_d;
  logic [ORW-1:0]      out_row_q, out_row_d;
  logic [GS_PXL_W-1:0] hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                phase_q, phase_d;
  logic [GS_PXL_W-1:0] lbuf_q [HCOL];

  logic dst_hsk;
  logic free;
  logic in_last;
  logic load_fill;
  logic load_rep;
  logic load;

  // Handshake and hold-stage availability
  always_comb begin
    dst_hsk = hold_vld_q & dst_rdy_i;
    free    = ~hold_vld_q | (dst_hsk & phase_q);
    in_last = (in_col_q == IC_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next state: flip row type when the last half-row pixel is loaded
  always_comb begin
    state_d = state_q;
    if (load && in_last) begin
      state_d = (state_q == FILL) ? REPLAY : FILL;
    end
  end

  // Outputs and load strobes
  always_comb begin
    src_pxl_rdy_o = (state_q == FILL) & free & ~rst;
    load_fill     = src_pxl_rdy_o & src_pxl_vld_i;
    load_rep      = (state_q == REPLAY) & free;
    load          = load_fill | load_rep;
    dst_pxl_o     = hold_q;
    dst_pxl_vld_o = hold_vld_q;
    dst_eol_o     = hold_vld_q & (out_col_q == OC_LAST);
    dst_eof_o     = dst_eol_o & (out_row_q == OR_LAST);
  end

  // Datapath next-state: hold stage, phase and counters
  always_comb begin
    in_col_d   = in_col_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    phase_d    = phase_q;
    out_col_d  = out_col_q;
    out_row_d  = out_row_q;
    if (dst_hsk) begin
      phase_d = ~phase_q;
      if (phase_q) hold_vld_d = 1'b0;
      if (out_col_q == OC_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == OR_LAST) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
    if (load) begin
      hold_vld_d = 1'b1;
      hold_d     = load_fill ? src_pxl_i : lbuf_q[in_col_q];
      in_col_d   = in_last ? '0 : in_col_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_col_q   <= '0;
      out_col_q  <= '0;
      out_row_q  <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      in_col_q   <= in_col_d;
      out_col_q  <= out_col_d;
      out_row_q  <= out_row_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      phase_q    <= phase_d;
    end
  end

  // Line buffer captures each even row for the odd-row replay
  always_ff @(posedge clk) begin
    if (load_fill) lbuf_q[in_col_q] <= src_pxl_i;
  end

endmodule

// File: tb/tb_pixel_upscaler_linebuf.sv
// Bench for pixel_upscaler_linebuf at 4x4 output.
// Scoreboard expects every source pixel twice, then the row again.
module tb_pixel_upscaler_linebuf;

  localparam int W = 8;
  localparam int C = 4;
  localparam int R = 4;
  localparam int H = C / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] src = '0;
  logic         src_vld = 1'b0;
  logic         src_rdy;
  logic [W-1:0] dst_pxl;
  logic         dst_vld;
  logic         dst_rdy = 1'b1;
  logic         dst_eol;
  logic         dst_eof;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] rb [H];
  int           fcnt = 0;
  int           ocnt = 0;
  logic [W-1:0] e;
  logic         stall_pend = 1'b0;
  logic [W-1:0] st_pxl;
  logic         st_eol;
  logic         st_eof;
  logic         done;

  pixel_upscaler_linebuf #(
    .GS_PXL_W (W),
    .COL_NUM  (C),
    .ROW_NUM  (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_pxl_i     (src),
    .src_pxl_vld_i (src_vld),
    .src_pxl_rdy_o (src_rdy),
    .dst_pxl_o     (dst_pxl),
    .dst_pxl_vld_o (dst_vld),
    .dst_rdy_i     (dst_rdy),
    .dst_eol_o     (dst_eol),
    .dst_eof_o     (dst_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard push on src handshake, pop on dst handshake
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      fcnt = 0;
      ocnt = 0;
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_vld", {31'd0, dst_vld}, 32'd1);
        chk("stall_pxl", {24'd0, dst_pxl}, {24'd0, st_pxl});
        chk("stall_eol", {31'd0, dst_eol}, {31'd0, st_eol});
        chk("stall_eof", {31'd0, dst_eof}, {31'd0, st_eof});
      end
      stall_pend = dst_vld && !dst_rdy;
      st_pxl = dst_pxl;
      st_eol = dst_eol;
      st_eof = dst_eof;
      if (dst_vld && dst_rdy) begin
        chk("sb_nonempty", {31'd0, q.size() > 0}, 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          popped++;
          chk("pxl", {24'd0, dst_pxl}, {24'd0, e});
          chk("eol", {31'd0, dst_eol}, {31'd0, (ocnt % C) == C - 1});
          chk("eof", {31'd0, dst_eof}, {31'd0, ocnt == C * R - 1});
          ocnt = (ocnt + 1) % (C * R);
        end
      end
      if (src_vld && src_rdy) begin
        q.push_back(src);
        q.push_back(src);
        pushed += 2;
        rb[fcnt] = src;
        fcnt++;
        if (fcnt == H) begin
          for (int i = 0; i < H; i++) begin
            q.push_back(rb[i]);
            q.push_back(rb[i]);
            pushed += 2;
          end
          fcnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] p);
    logic got;
    got = 1'b0;
    src = p;
    src_vld = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = src_rdy;
    end
    chk("send_timeout", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    src_vld = 1'b0;
  endtask

  task automatic drain();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (q.size() == 0) && !dst_vld;
    end
    chk("drain_timeout", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_src_rdy", {31'd0, src_rdy}, 32'd0);
    chk("rst_vld", {31'd0, dst_vld}, 32'd0);
    chk("rst_pxl", {24'd0, dst_pxl}, 32'd0);
    chk("rst_eol", {31'd0, dst_eol}, 32'd0);
    chk("rst_eof", {31'd0, dst_eof}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_vld", {31'd0, dst_vld}, 32'd0);
    chk("post_rst_rdy", {31'd0, src_rdy}, 32'd1);
    @(posedge clk);
    #1;

    // Frame 1: back-to-back, always ready
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    drain();

    // Frame 2: random downstream stalls
    done = 1'b0;
    fork
      begin
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          dst_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    dst_rdy = 1'b1;

    // Frame 3: source starves for 5 cycles after the first pixel
    send(8'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) chk("starve_vld", {31'd0, dst_vld}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'd2);
    send(8'd3);
    send(8'd4);
    drain();

    // Frame 4: source offers 0xAA throughout the replay row
    send(8'd5);
    send(8'd6);
    src = 8'hAA;
    src_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("replay_rdy", {31'd0, src_rdy}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'hAA);
    send(8'hBB);
    drain();

    // Frame 5: reset in the middle of the replay row
    send(8'd1);
    send(8'd2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_vld", {31'd0, dst_vld}, 32'd0);
    chk("midrst_pxl", {24'd0, dst_pxl}, 32'd0);
    @(posedge clk);
    #1;
    pushed = 0;
    popped = 0;
    send(8'd9);
    send(8'd8);
    send(8'd7);
    send(8'd6);
    drain();
    chk("out_count", popped, 32'd16);
    chk("pushed_popped", popped, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
